// File: rtl/pulse_train_generator.sv
// Pulse train generator: emits `count` high pulses of `pulse_width` cycles
// separated by max(gap,1) low cycles, then a one-cycle done strobe.
module pulse_train_generator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] pulse_width,
    input  logic [CNT_W-1:0] gap,
    input  logic [CNT_W-1:0] count,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] pulse_idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             out_q, out_d;
    logic             aborted_q, aborted_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            width_q   <= '0;
            gap_q     <= '0;
            count_q   <= '0;
            phase_q   <= '0;
            idx_q     <= '0;
            out_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            gap_q     <= gap_d;
            count_q   <= count_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            out_q     <= out_d;
            aborted_q <= aborted_d;
        end
    end

    // phase_q counts down the remaining cycles of the current HIGH/LOW phase,
    // loaded with length-1 so a full-scale width never overflows.
    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        gap_d     = gap_q;
        count_d   = count_q;
        phase_d   = phase_q;
        idx_d     = idx_q;
        aborted_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d = '0;
                    if (count == '0 || pulse_width == '0) begin
                        state_d = S_DONE;
                    end else begin
                        width_d = pulse_width;
                        gap_d   = gap;
                        count_d = count;
                        phase_d = pulse_width - ONE;
                        state_d = S_HIGH;
                    end
                end
            end
            S_HIGH: begin
                if (abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (phase_q == '0) begin
                    if (idx_q < count_q - ONE) begin
                        state_d = S_LOW;
                        phase_d = (gap_q == '0) ? '0 : gap_q - ONE;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    phase_d = phase_q - ONE;
                end
            end
            S_LOW: begin
                if (abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (phase_q == '0) begin
                    idx_d   = idx_q + ONE;
                    phase_d = width_q - ONE;
                    state_d = S_HIGH;
                end else begin
                    phase_d = phase_q - ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        out_d     = (state_d == S_HIGH);
        out       = out_q;
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        aborted   = aborted_q;
        pulse_idx = idx_q;
    end

endmodule
